// File: rtl/stim_gen_pkg.sv
// Shared types, opcode constants and the xorshift32 step for the RV32I stimulus generator.
package stim_gen_pkg;

    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [31:0] RV_NOP    = 32'h00000013;

    typedef enum logic [1:0] {
        CLS_OPIMM = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_OP    = 2'd2,
        CLS_STORE = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2
    } st_e;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/rv32_instr_encode.sv
// Combinational encoder: one xorshift word plus the class enables -> one legal RV32I instruction.
// With STIM_REG_WINDOW_EN defined, register fields are confined to 0..REG_WINDOW-1.
module rv32_instr_encode
    import stim_gen_pkg::*;
#(
    parameter logic [2:0]  LOAD_F3_MASK   = 3'b100,
    parameter logic [11:0] LOAD_IMM_MASK  = 12'h03C,
    parameter logic [11:0] STORE_IMM_MASK = 12'h03C,
    parameter int          REG_WINDOW     = 4
) (
    input  logic [31:0] r,
    input  logic [3:0]  class_en,
    output logic [31:0] word
);

`ifdef STIM_REG_WINDOW_EN
    localparam logic [4:0] REG_MASK = 5'(REG_WINDOW - 1);
`else
    // Full register range; the window term is absorbed by the all-ones mask.
    localparam logic [4:0] REG_MASK = 5'h1F | 5'(REG_WINDOW - 1);
`endif

    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [11:0] opimm_imm;
    logic [11:0] st_imm;
    logic [6:0]  f7;
    logic [2:0]  sf3;
    logic [1:0]  cand [4];
    logic [3:0]  avail;
    cls_e        sel;

    assign f3  = r[4:2];
    assign rs1 = r[14:10] & REG_MASK;
    assign rs2 = r[19:15] & REG_MASK;
    assign imm = r[31:20];

    // Candidate k is the class k steps above the drawn one (mod 4).
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi]  = r[1:0] + 2'(gi);
        assign avail[gi] = class_en[cand[gi]];
    end

    always_comb begin
        sel = cls_e'(cand[0]);
        for (int k = 3; k >= 0; k--) begin
            if (avail[k]) begin
                sel = cls_e'(cand[k]);
            end
        end
    end

    always_comb begin
        rd = r[9:5] & REG_MASK;
`ifdef STIM_REG_WINDOW_EN
        if (sel != CLS_STORE && rd == 5'd0) begin
            rd = 5'd1;
        end
`endif
        opimm_imm = imm;
        if (f3 == 3'd1) begin
            opimm_imm = imm & 12'h01F;
        end else if (f3 == 3'd5) begin
            opimm_imm = imm & 12'h41F;
        end
        f7     = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, imm[10], 5'b0} : 7'b0;
        sf3    = (f3[1:0] == 2'd3) ? 3'b010 : {1'b0, f3[1:0]};
        st_imm = imm & STORE_IMM_MASK;

        case (sel)
            CLS_OPIMM: word = {opimm_imm, rs1, f3, rd, OPC_OPIMM};
            CLS_LOAD:  word = {imm & LOAD_IMM_MASK, rs1, f3 & LOAD_F3_MASK, rd, OPC_LOAD};
            CLS_OP:    word = {f7, rs2, rs1, f3, rd, OPC_OP};
            default:   word = {st_imm[11:5], rs2, rs1, sf3, st_imm[4:0], OPC_STORE};
        endcase

        if (class_en == 4'b0000) begin
            word = RV_NOP;
        end
    end

endmodule

// File: rtl/rv32_instr_stim_gen.sv
// Seeded, stall-independent RV32I instruction source on a valid/ready stream.
// Optional register windowing is enabled by defining STIM_REG_WINDOW_EN.
module rv32_instr_stim_gen
    import stim_gen_pkg::*;
#(
    parameter logic [31:0] SEED           = 32'h1,
    parameter int          NOP_WARMUP     = 3,
    parameter int          NUM_INSTR      = 100,
    parameter logic [2:0]  LOAD_F3_MASK   = 3'b100,
    parameter logic [11:0] LOAD_IMM_MASK  = 12'h03C,
    parameter logic [11:0] STORE_IMM_MASK = 12'h03C,
    parameter int          REG_WINDOW     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  class_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_count,
    output logic        done
);

    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'h1 : SEED;
    localparam st_e         ST_INIT   = (NOP_WARMUP == 0) ? ST_RUN : ST_WARMUP;
    localparam logic [31:0] WARM_LAST = 32'(NOP_WARMUP - 1);
    localparam logic [31:0] LIMIT     = 32'(NUM_INSTR);

    st_e         state_reg, state_next;
    logic [31:0] lfsr_reg, lfsr_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] warm_reg, warm_next;
    logic [31:0] r;
    logic [31:0] enc_word;

    // The word on offer is derived from the current lfsr, so it holds while stalled.
    assign r = xorshift32(lfsr_reg);

    rv32_instr_encode #(
        .LOAD_F3_MASK   (LOAD_F3_MASK),
        .LOAD_IMM_MASK  (LOAD_IMM_MASK),
        .STORE_IMM_MASK (STORE_IMM_MASK),
        .REG_WINDOW     (REG_WINDOW)
    ) u_encode (
        .r        (r),
        .class_en (class_en),
        .word     (enc_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
            lfsr_reg  <= SEED_EFF;
            count_reg <= 32'd0;
            warm_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            count_reg <= count_next;
            warm_reg  <= warm_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        count_next = count_reg;
        warm_next  = warm_reg;
        out_valid  = 1'b1;
        out_data   = RV_NOP;
        done       = 1'b0;

        if (!reset) begin
            case (state_reg)
                ST_WARMUP: begin
                    if (out_ready) begin
                        if (warm_reg == WARM_LAST) begin
                            state_next = ST_RUN;
                        end else begin
                            warm_next = warm_reg + 32'd1;
                        end
                    end
                end
                ST_RUN: begin
                    out_data = enc_word;
                    if (out_ready) begin
                        lfsr_next  = r;
                        count_next = count_reg + 32'd1;
                        if (NUM_INSTR != 0 && count_next == LIMIT) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    out_valid = 1'b0;
                    done      = 1'b1;
                end
                default: begin
                    state_next = ST_WARMUP;
                end
            endcase
        end
    end

    assign out_count = count_reg;

endmodule

// File: tb/tb_rv32_instr_stim_gen.sv
// Bench: two generators (unbounded and NUM_INSTR=5) checked every cycle against an arithmetic model.
module tb_rv32_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  class_en = 4'hF;
    logic [1:0]  rdy = 2'b11;
    logic [1:0]  dv;
    logic [1:0]  ddn;
    logic [31:0] dd [2];
    logic [31:0] dc [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32_instr_stim_gen #(.NUM_INSTR(0)) u_main (
        .clk(clk), .reset(reset), .class_en(class_en),
        .out_valid(dv[0]), .out_ready(rdy[0]), .out_data(dd[0]),
        .out_count(dc[0]), .done(ddn[0])
    );

    rv32_instr_stim_gen #(.NUM_INSTR(5)) u_lim (
        .clk(clk), .reset(reset), .class_en(class_en),
        .out_valid(dv[1]), .out_ready(rdy[1]), .out_data(dd[1]),
        .out_count(dc[1]), .done(ddn[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned xs(input int unsigned x);
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] model_enc(input int unsigned r, input logic [3:0] en);
        int unsigned cls, f3, rd, rs1, rs2, imm, f7, sf3;
        cls = r % 4;
        f3  = (r / 4) % 8;
        rd  = (r / 32) % 32;
        rs1 = (r / 1024) % 32;
        rs2 = (r / 32768) % 32;
        imm = r / 1048576;
        if (en == 4'b0000) return NOP;
        while (en[cls] == 1'b0) cls = (cls + 1) % 4;
`ifdef STIM_REG_WINDOW_EN
        rd = rd % 4; rs1 = rs1 % 4; rs2 = rs2 % 4;
        if (cls != 3 && rd == 0) rd = 1;
`endif
        case (cls)
            0: begin
                if (f3 == 1) imm = imm % 32;
                else if (f3 == 5) imm = (imm & 'h400) + imm % 32;
                return imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 'h13;
            end
            1: return (imm & 'h03C) * 1048576 + rs1 * 32768 + (f3 & 4) * 4096 + rd * 128 + 'h03;
            2: begin
                f7 = (f3 == 0 || f3 == 5) ? ((imm / 1024) % 2) * 32 : 0;
                return f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 'h33;
            end
            default: begin
                sf3 = (f3 % 4 == 3) ? 2 : f3 % 4;
                imm = imm & 'h03C;
                return (imm / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + sf3 * 4096
                       + (imm % 32) * 128 + 'h23;
            end
        endcase
    endfunction

    int unsigned m_lfsr [2];
    int unsigned m_count [2];
    int unsigned m_warm [2];
    logic        e_valid, e_done;
    logic [31:0] e_data;
    logic [1:0]  prev_stall = 2'b00;
    logic [31:0] prev_data [2];
    logic [31:0] acc_q [$];
    logic [31:0] ref_q [$];

    // Inputs change only just after posedge, so at negedge they equal what the next edge samples.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_done = 1'b0;
            e_data = NOP;
            e_valid = 1'b1;
            if (!reset && m_warm[k] == 0) begin
                if (k == 1 && m_count[k] == 5) begin
                    e_valid = 1'b0;
                    e_done  = 1'b1;
                end else begin
                    e_data = model_enc(xs(m_lfsr[k]), class_en);
                end
            end
            chk($sformatf("valid%0d", k), {31'b0, dv[k]}, {31'b0, e_valid});
            chk($sformatf("data%0d", k), dd[k], e_data);
            if (!reset) begin
                chk($sformatf("count%0d", k), dc[k], m_count[k]);
                chk($sformatf("done%0d", k), {31'b0, ddn[k]}, {31'b0, e_done});
                if (prev_stall[k]) chk($sformatf("stall_hold%0d", k), dd[k], prev_data[k]);
            end
            if (k == 0 && !reset && m_warm[0] == 0 && class_en == 4'b0001) begin
                chk("t3_opcode", {25'b0, dd[0][6:0]}, 32'h13);
                if (dd[0][14:12] == 3'd1 || dd[0][14:12] == 3'd5)
                    chk("t3_shamt", {31'b0, (dd[0][31:25] == 7'h00 || dd[0][31:25] == 7'h20)}, 32'd1);
            end
            prev_stall[k] = !reset && dv[k] && !rdy[k];
            prev_data[k]  = dd[k];
            if (reset) begin
                m_lfsr[k]  = 1;
                m_warm[k]  = 3;
                m_count[k] = 0;
            end else if (e_valid && rdy[k]) begin
                if (m_warm[k] > 0) begin
                    m_warm[k]--;
                end else begin
                    if (k == 0) acc_q.push_back(dd[0]);
                    m_lfsr[k] = xs(m_lfsr[k]);
                    m_count[k]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input logic [3:0] en);
        @(posedge clk); #1;
        reset = 1'b1;
        class_en = en;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        acc_q.delete();
    endtask

    task automatic wait_acc(input int n);
        for (int c = 0; c < 600 && acc_q.size() < n; c++) begin
            @(posedge clk); #1;
            rdy[0] = 1'($urandom_range(0, 1)) | (n < 0);
        end
        rdy[0] = 1'b1;
        chk("acc_timeout", acc_q.size() >= n, 32'd1);
    endtask

    initial begin
        // T1 / T4: warmup, first word, bounded instance reaching done
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_first_word", dd[0], 32'h00040083);
        chk("t1_count0", dc[0], 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_count1", dc[0], 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t4_done", {31'b0, ddn[1]}, 32'd1);
        chk("t4_valid", {31'b0, dv[1]}, 32'd0);
        chk("t4_count", dc[1], 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_done_hold", {31'b0, ddn[1]}, 32'd1);
        chk("t4_count_hold", dc[1], 32'd5);
        for (int c = 0; c < 100 && acc_q.size() < 20; c++) @(posedge clk);
        chk("t1_collected", acc_q.size() >= 20, 32'd1);
        ref_q = acc_q;
        if (ref_q.size() > 0) chk("t1_ref_head", ref_q[0], 32'h00040083);

        // T2: random back-pressure must not change the accepted sequence
        do_reset(4'hF);
        wait_acc(20);
        for (int i = 0; i < 20 && i < acc_q.size() && i < ref_q.size(); i++)
            chk($sformatf("t2_seq[%0d]", i), acc_q[i], ref_q[i]);

        // T5: reset mid-run restarts the identical stream
        do_reset(4'hF);
        for (int c = 0; c < 100 && dc[0] != 32'd7; c++) begin
            @(posedge clk); #1;
        end
        chk("t5_reached7", dc[0], 32'd7);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_nop_in_reset", dd[0], NOP);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_count_cleared", dc[0], 32'd0);
        chk("t5_done_cleared", {31'b0, ddn[1]}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5_restart_word", dd[0], 32'h00040083);

        // T3: OP-IMM only, long run
        do_reset(4'b0001);
        repeat (10010) @(posedge clk);
        @(negedge clk);
        chk("t3_count", dc[0], 32'd10007);

        // T6: no class enabled -> NOPs, counter still advances
        do_reset(4'b0000);
        repeat (33) @(posedge clk);
        @(negedge clk);
        chk("t6_count", dc[0], 32'd30);
        chk("t6_nop", dd[0], NOP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
